// File: rtl/cdb_pkg.sv
// Shared CDB packet type and default field widths, used by the issuer,
// the reservation stations and the CDB arbiter.
package cdb_pkg;

    localparam int CDB_TAG_W = 4;
    localparam int CDB_VAL_W = 8;
    localparam int CDB_ROB_W = 8;

    typedef struct packed {
        logic [CDB_VAL_W-1:0] val;
        logic [CDB_TAG_W-1:0] tag;
        logic [CDB_ROB_W-1:0] robid;
    } cdb_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr (wrapping modulo N) wins; the caller owns and advances ptr.
module rr_arbiter #(
    parameter int N = 8,
    localparam int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx
);

    localparam int unsigned N_U = N;

    int unsigned      base;
    int unsigned      idx;
    logic [PTR_W-1:0] sel;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        base      = 32'(ptr);
        idx       = 0;
        sel       = '0;
        for (int unsigned k = 0; k < N_U; k++) begin
            idx = (base + k) % N_U;
            sel = PTR_W'(idx);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per FU, round-robin selection of
// one held result per cycle onto a registered CDB, per-FU backpressure.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int FU_COUNT = 8,
    parameter int TAG_W    = CDB_TAG_W,
    parameter int VAL_W    = CDB_VAL_W,
    parameter int ROB_W    = CDB_ROB_W,
    localparam int CNT_W   = $clog2(FU_COUNT + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic [FU_COUNT-1:0]                fu_done,
    input  logic [FU_COUNT-1:0][VAL_W-1:0]     fu_result,
    input  logic [FU_COUNT-1:0][TAG_W-1:0]     fu_tag,
    input  logic [FU_COUNT-1:0][ROB_W-1:0]     fu_robid,
    output logic [FU_COUNT-1:0]                fu_accept,
    output logic [VAL_W-1:0]                   cdbval,
    output logic [TAG_W-1:0]                   cdbid,
    output logic [ROB_W-1:0]                   cdbrobid,
    output logic                               cdbtransmit,
    output logic [CNT_W-1:0]                   held_count
);

    localparam int PTR_W = $clog2(FU_COUNT);

    typedef struct packed {
        logic [VAL_W-1:0] val;
        logic [TAG_W-1:0] tag;
        logic [ROB_W-1:0] robid;
    } slot_t;

    slot_t [FU_COUNT-1:0] slot;
    logic  [FU_COUNT-1:0] valid;
    logic  [FU_COUNT-1:0] valid_next;
    logic  [FU_COUNT-1:0] grant;
    logic  [FU_COUNT-1:0] load;
    logic  [PTR_W-1:0]    ptr;
    logic  [PTR_W-1:0]    grant_idx;
    logic  [PTR_W-1:0]    ptr_next;
    logic  [CNT_W-1:0]    count_next;
    logic                 live;

    rr_arbiter #(.N(FU_COUNT)) u_rr (
        .req       (valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign live = !rst && !flush;

    // A slot being granted this cycle frees up in time to be refilled.
    always_comb begin
        fu_accept  = {FU_COUNT{live}} & (~valid | grant);
        load       = fu_done & fu_accept;
        valid_next = load | (valid & ~grant);
        ptr_next   = (grant_idx == PTR_W'(FU_COUNT - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_comb begin
        count_next = '0;
        for (int unsigned i = 0; i < FU_COUNT; i++) begin
            count_next = count_next + CNT_W'(valid_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < FU_COUNT; i++) begin
            if (load[i]) begin
                slot[i] <= '{val: fu_result[i], tag: fu_tag[i], robid: fu_robid[i]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid       <= '0;
            ptr         <= '0;
            cdbtransmit <= 1'b0;
            cdbval      <= '0;
            cdbid       <= '0;
            cdbrobid    <= '0;
            held_count  <= '0;
        end else if (flush) begin
            valid       <= '0;
            cdbtransmit <= 1'b0;
            held_count  <= '0;
        end else begin
            valid       <= valid_next;
            held_count  <= count_next;
            cdbtransmit <= |grant;
            if (|grant) begin
                cdbval   <= slot[grant_idx].val;
                cdbid    <= slot[grant_idx].tag;
                cdbrobid <= slot[grant_idx].robid;
                ptr      <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized checks of cdb_arbiter against a slot/queue-level
// reference model kept in the bench.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                              rst;
    logic                              flush;
    logic [N-1:0]                      fu_done;
    logic [N-1:0][CDB_VAL_W-1:0]       fu_result;
    logic [N-1:0][CDB_TAG_W-1:0]       fu_tag;
    logic [N-1:0][CDB_ROB_W-1:0]       fu_robid;
    logic [N-1:0]                      fu_accept;
    logic [CDB_VAL_W-1:0]              cdbval;
    logic [CDB_TAG_W-1:0]              cdbid;
    logic [CDB_ROB_W-1:0]              cdbrobid;
    logic                              cdbtransmit;
    logic [$clog2(N+1)-1:0]            held_count;

    cdb_arbiter #(
        .FU_COUNT (N),
        .TAG_W    (CDB_TAG_W),
        .VAL_W    (CDB_VAL_W),
        .ROB_W    (CDB_ROB_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fu_done     (fu_done),
        .fu_result   (fu_result),
        .fu_tag      (fu_tag),
        .fu_robid    (fu_robid),
        .fu_accept   (fu_accept),
        .cdbval      (cdbval),
        .cdbid       (cdbid),
        .cdbrobid    (cdbrobid),
        .cdbtransmit (cdbtransmit),
        .held_count  (held_count)
    );

    // Reference model state.
    bit       m_valid [N];
    cdb_pkt_t m_slot  [N];
    int       m_ptr;
    bit       m_tx;
    cdb_pkt_t m_cdb;

    int passed = 0;
    int total  = 0;
    int seen [N];
    bit counting = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int m_winner();
        for (int k = 0; k < N; k++) begin
            if (m_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_accept();
        logic [N-1:0] a;
        int w = m_winner();
        for (int i = 0; i < N; i++) a[i] = !rst && !flush && (!m_valid[i] || w == i);
        return a;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    task automatic m_edge();
        logic [N-1:0] acc = m_accept();
        int w = m_winner();
        if (rst) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            m_ptr = 0;
            m_tx  = 1'b0;
            m_cdb = '0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            m_tx = 1'b0;
        end else begin
            m_tx = (w >= 0);
            if (w >= 0) begin
                m_cdb      = m_slot[w];
                m_valid[w] = 1'b0;
                m_ptr      = (w + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (fu_done[i] && acc[i]) begin
                    m_valid[i] = 1'b1;
                    m_slot[i]  = '{val: fu_result[i], tag: fu_tag[i], robid: fu_robid[i]};
                end
            end
        end
    endtask

    // Starts and ends at a falling edge; inputs must already be driven.
    task automatic cycle();
        #1;
        check("fu_accept", 32'(fu_accept), 32'(m_accept()));
        @(posedge clk);
        m_edge();
        #1;
        check("cdbtransmit", 32'(cdbtransmit), 32'(m_tx));
        check("held_count", 32'(held_count), 32'(m_count()));
        check("cdbval", 32'(cdbval), 32'(m_cdb.val));
        check("cdbid", 32'(cdbid), 32'(m_cdb.tag));
        check("cdbrobid", 32'(cdbrobid), 32'(m_cdb.robid));
        if (counting && cdbtransmit && int'(cdbid) < N) seen[int'(cdbid)]++;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        fu_done   = '0;
        fu_result = '0;
        fu_tag    = '0;
        fu_robid  = '0;
    endtask

    task automatic set_fu(input int i, input logic [7:0] v, input logic [3:0] t, input logic [7:0] r);
        fu_done[i]   = 1'b1;
        fu_result[i] = v;
        fu_tag[i]    = t;
        fu_robid[i]  = r;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int exp_id [3] = '{0, 2, 5};
        rst   = 1'b1;
        flush = 1'b0;
        clear_inputs();
        for (int i = 0; i < N; i++) seen[i] = 0;
        @(negedge clk);

        // Reset, then idle.
        cycle();
        cycle();
        check("rst_accept", 32'(fu_accept), 32'h0);
        check("rst_tx", 32'(cdbtransmit), 32'h0);
        check("rst_held", 32'(held_count), 32'h0);
        check("rst_val", 32'(cdbval), 32'h0);
        rst = 1'b0;
        #1;
        check("idle_accept", 32'(fu_accept), 32'hFF);
        cycle();

        // Single result from FU 3: visible on the bus two cycles later, once.
        set_fu(3, 8'h5A, 4'h7, 8'h12);
        cycle();
        clear_inputs();
        check("single_n1_tx", 32'(cdbtransmit), 32'h0);
        check("single_n1_held", 32'(held_count), 32'h1);
        cycle();
        check("single_n2_tx", 32'(cdbtransmit), 32'h1);
        check("single_n2_val", 32'(cdbval), 32'h5A);
        check("single_n2_id", 32'(cdbid), 32'h7);
        check("single_n2_rob", 32'(cdbrobid), 32'h12);
        cycle();
        check("single_n3_tx", 32'(cdbtransmit), 32'h0);

        // Contention among FUs 0, 2, 5 with ptr at 0.
        reset_pulse();
        set_fu(0, 8'hA0, 4'd0, 8'h30);
        set_fu(2, 8'hA2, 4'd2, 8'h32);
        set_fu(5, 8'hA5, 4'd5, 8'h35);
        cycle();
        clear_inputs();
        check("contend_held", 32'(held_count), 32'd3);
        #1;
        check("contend_accept", 32'(fu_accept), 32'hDB);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("contend_tx", 32'(cdbtransmit), 32'h1);
            check("contend_id", 32'(cdbid), 32'(exp_id[k]));
            check("contend_held_dec", 32'(held_count), 32'(2 - k));
        end

        // All FUs complete every cycle: strict rotation with no bus gaps.
        reset_pulse();
        for (int i = 0; i < N; i++) set_fu(i, 8'(i * 16 + 1), 4'(i), 8'(i));
        cycle();
        counting = 1'b1;
        for (int k = 0; k < 32; k++) begin
            cycle();
            check("fair_tx", 32'(cdbtransmit), 32'h1);
            check("fair_order", 32'(cdbid), 32'(k % N));
        end
        counting = 1'b0;
        for (int i = 0; i < N; i++) check("fair_count", 32'(seen[i]), 32'd4);
        clear_inputs();
        for (int k = 0; k < 10; k++) cycle();
        check("drain_held", 32'(held_count), 32'h0);

        // FU 1 alone: refill in the grant cycle, one broadcast per cycle.
        for (int k = 0; k < 20; k++) begin
            set_fu(1, 8'(8'h40 + k), 4'h1, 8'(k));
            #1;
            check("refill_accept", 32'(fu_accept[1]), 32'h1);
            cycle();
            if (k > 0) begin
                check("refill_tx", 32'(cdbtransmit), 32'h1);
                check("refill_val", 32'(cdbval), 32'(8'h40 + k - 1));
            end
        end
        clear_inputs();
        cycle();
        cycle();

        // Flush with four slots held and a broadcast on the bus.
        for (int i = 0; i < 5; i++) set_fu(i, 8'(8'hC0 + i), 4'(i), 8'(8'h50 + i));
        cycle();
        clear_inputs();
        cycle();
        check("preflush_held", 32'(held_count), 32'd4);
        check("preflush_tx", 32'(cdbtransmit), 32'h1);
        flush = 1'b1;
        set_fu(6, 8'hE6, 4'd6, 8'h66);
        cycle();
        flush = 1'b0;
        clear_inputs();
        check("flush_held", 32'(held_count), 32'h0);
        for (int k = 0; k < 6; k++) begin
            check("postflush_tx", 32'(cdbtransmit), 32'h0);
            cycle();
        end
        check("postflush_end_tx", 32'(cdbtransmit), 32'h0);

        // Randomized traffic with occasional flush and reset.
        for (int k = 0; k < 400; k++) begin
            fu_done   = N'($urandom);
            fu_result = {$urandom, $urandom};
            fu_tag    = 32'($urandom);
            fu_robid  = {$urandom, $urandom};
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 59) == 0);
            cycle();
        end
        rst   = 1'b0;
        flush = 1'b0;
        clear_inputs();
        for (int k = 0; k < 10; k++) cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the single common data bus (CDB) between the functional units fed by the issuer's reservation stations. Each FU deposits a completed result into a one-entry holding register. A round-robin arbiter selects one held result per cycle and drives the registered CDB (`cdbval`/`cdbid`/`cdbtransmit`) that the reservation stations snoop. Per-FU backpressure stops an FU from completing while its holding slot is occupied.

## Interface
- `FU_COUNT`, default 8: number of functional units / requesters (≥2).
- `TAG_W`, default 4: width of the CDB destination tag (`cdbid`).
- `VAL_W`, default 8: width of the result value.
- `ROB_W`, default 8: width of the ROB id.

Ports (`name direction width meaning`):
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: pipeline flush; discards all held and pending results.
- `fu_done` in [FU_COUNT]: FU i presents a completed result this cycle.
- `fu_result` in [FU_COUNT][VAL_W]: result value per FU.
- `fu_tag` in [FU_COUNT][TAG_W]: destination tag per FU.
- `fu_robid` in [FU_COUNT][ROB_W]: ROB id per FU.
- `fu_accept` out [FU_COUNT]: holding slot i can take a result this cycle (combinational).
- `cdbval` out VAL_W: broadcast value.
- `cdbid` out TAG_W: broadcast tag.
- `cdbrobid` out ROB_W: broadcast ROB id.
- `cdbtransmit` out 1: CDB carries a valid broadcast this cycle.
- `held_count` out $clog2(FU_COUNT+1): number of occupied holding slots.

## Operation
- Holding slot i is {valid, val, tag, robid}. It loads on `fu_done[i] && fu_accept[i]`.
- `fu_accept[i] = !rst && !flush && (!valid[i] || grant[i])`. A slot granted this cycle can be refilled in the same cycle.
- `fu_done[i]` with `fu_accept[i]=0` is an FU protocol violation. The FU must hold its result; the arbiter ignores it.
- Grant: combinational round-robin over `valid[]`. The search starts at pointer `ptr`, wrapping modulo FU_COUNT. At most one grant per cycle.
- On grant to i: CDB output registers load slot i and `cdbtransmit` is set next cycle. `valid[i]` clears unless it is reloaded the same cycle. `ptr` becomes (i+1) mod FU_COUNT.
- No grant: `cdbtransmit` is 0 next cycle, CDB data registers hold their old values, and `ptr` is unchanged.
- Fairness: a valid slot is granted within FU_COUNT cycles of becoming valid.
- `flush`: next cycle all `valid` = 0 and `cdbtransmit` = 0. `fu_done` in the flush cycle is dropped. `ptr` is unchanged.
- `held_count` is the registered popcount of `valid[]`. It reflects state after the current edge.

## Timing
- Reset (edge with `rst`=1): all `valid` = 0, `ptr` = 0, `cdbtransmit` = 0, `cdbval`/`cdbid`/`cdbrobid` = 0, `held_count` = 0. `fu_accept` = 0 while `rst` is high.
- Latency: `fu_done` at cycle N, then slot valid at N+1, then earliest `cdbtransmit` at N+2.
- Throughput: one broadcast per cycle sustained while any slot is valid. A single FU can complete every cycle and broadcast every cycle, provided it is the only requester.
- `rst` has priority over `flush`, and `flush` has priority over load and grant.
- Reset or flush mid-stream: the broadcast already on the bus in the flush cycle completes. Nothing else emerges afterwards.

## Structure
- Shared package `cdb_pkg`: `cdb_pkt_t` struct {val, tag, robid} and the `TAG_W`/`VAL_W`/`ROB_W` defaults. The issuer and the reservation stations reuse the same package.
- Sub-module `rr_arbiter` (parameter N): inputs `req[N]` and `ptr`; outputs one-hot `grant[N]` and `grant_idx`. Purely combinational. `cdb_arbiter` owns `ptr`.
- Top level: holding-register array, CDB output registers, pointer update, and popcount.

## Test plan
- Reset then idle: `rst` for 2 cycles, then `fu_done`=0 → all outputs 0, `fu_accept` all 1 after reset.
- Single result: `fu_done[3]` with val=0x5A, tag=0x7, robid=0x12 at cycle N → `cdbtransmit`=1, `cdbval`=0x5A, `cdbid`=0x7, `cdbrobid`=0x12 at N+2 only.
- Contention: FUs 0, 2 and 5 complete at the same cycle with `ptr`=0 → broadcasts in order 0, 2, 5 on three consecutive cycles. Meanwhile `fu_accept[2]`/`fu_accept[5]` = 0 while waiting, and `held_count` goes 3→2→1→0.
- Round-robin fairness: all 8 FUs complete every cycle for 32 cycles → grants rotate 0..7 repeatedly, each FU is granted exactly 4 times, and there are no gaps in `cdbtransmit`.
- Grant-and-refill: FU 1 alone asserts `fu_done` every cycle with an incrementing value → `fu_accept[1]` stays 1 and the CDB shows consecutive values every cycle.
- Flush: 4 slots valid, `flush` pulsed for one cycle along with `fu_done[6]` → the broadcast in the flush cycle completes, `cdbtransmit`=0 thereafter, `held_count`=0, and FU 6's result never appears.
